// File: rtl/shift_issue_stage.sv
// Two-entry issue/retire stage around an external combinational barrel shifter.
// S1 holds the decoded MIPS shift op and drives the shifter; S2 captures the result.
module shift_issue_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [5:0]   in_funct,
    input  logic [4:0]   in_shamt,
    input  logic [N-1:0] in_rs,
    input  logic [N-1:0] in_rt,
    input  logic [4:0]   in_rd,
    output logic [N-1:0] sh_in,
    output logic [4:0]   sh_sl,
    output logic         sh_dir,
    output logic [1:0]   sh_mode,
    input  logic [N-1:0] sh_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [4:0]   out_rd,
    output logic         out_err
);

    typedef enum logic [1:0] {
        MODE_LOGICAL = 2'b00,
        MODE_ROTATE  = 2'b01,
        MODE_ARITH   = 2'b10
    } mode_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    logic [4:0] dec_sl;
    logic       dec_dir;
    mode_e      dec_mode;
    logic       dec_err;

    logic         s1_valid;
    logic [N-1:0] s1_rt;
    logic [4:0]   s1_sl;
    logic         s1_dir;
    mode_e        s1_mode;
    logic [4:0]   s1_rd;
    logic         s1_err;

    logic         s2_valid;
    logic [N-1:0] s2_data;
    logic [4:0]   s2_rd;
    logic         s2_err;

    logic s2_free;
    logic s1_adv;
    logic accept;

    // Only rs[4:0] is a shift amount; the upper bits are deliberately ignored.
    logic unused_rs_hi;
    assign unused_rs_hi = ^in_rs[N-1:5];

    always_comb begin
        // NOTE: every decode output gets a default before the case, so no path can infer a latch.
        dec_sl   = in_funct[2] ? in_rs[4:0] : in_shamt;
        dec_dir  = DIR_RIGHT;
        dec_mode = MODE_LOGICAL;
        dec_err  = 1'b0;
        case (in_funct)
            6'b000000: dec_dir = DIR_LEFT;                                    // SLL
            6'b000010: dec_mode = MODE_LOGICAL;                               // SRL
            6'b000011: dec_mode = MODE_ARITH;                                 // SRA
            6'b000001: dec_mode = MODE_ROTATE;                                // ROTR
            6'b000100: dec_dir = DIR_LEFT;                                    // SLLV
            6'b000110: dec_mode = MODE_LOGICAL;                               // SRLV
            6'b000111: dec_mode = MODE_ARITH;                                 // SRAV
            6'b000101: dec_mode = MODE_ROTATE;                                // ROTRV
            default: begin
                // Unsupported funct: shifter passes rt through, flagged as error.
                dec_sl  = 5'd0;
                dec_dir = DIR_LEFT;
                dec_err = 1'b1;
            end
        endcase
    end

    assign s2_free  = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s1_adv;
    assign accept   = in_valid && in_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_rt    <= '0;
            s1_sl    <= '0;
            s1_dir   <= DIR_LEFT;
            s1_mode  <= MODE_LOGICAL;
            s1_rd    <= '0;
            s1_err   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_rt    <= in_rt;
            s1_sl    <= dec_sl;
            s1_dir   <= dec_dir;
            s1_mode  <= dec_mode;
            s1_rd    <= in_rd;
            s1_err   <= dec_err;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Shifter controls come straight from S1, so they hold while S1 is empty.
    assign sh_in   = s1_rt;
    assign sh_sl   = s1_sl;
    assign sh_dir  = s1_dir;
    assign sh_mode = s1_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_rd    <= '0;
            s2_err   <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_data  <= sh_out;
            s2_rd    <= s1_rd;
            s2_err   <= s1_err;
        end else if (s2_valid && out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_rd    = s2_rd;
    assign out_err   = s2_err;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage: directed vector table, hand-written
// backpressure/reset sequences, and randomized streaming against a reference model.
module tb_shift_issue_stage;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [5:0]   in_funct;
    logic [4:0]   in_shamt;
    logic [N-1:0] in_rs;
    logic [N-1:0] in_rt;
    logic [4:0]   in_rd;
    logic [N-1:0] sh_in;
    logic [4:0]   sh_sl;
    logic         sh_dir;
    logic [1:0]   sh_mode;
    logic [N-1:0] sh_out;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [4:0]   out_rd;
    logic         out_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_issue_stage #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct(in_funct), .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .sh_in(sh_in), .sh_sl(sh_sl), .sh_dir(sh_dir), .sh_mode(sh_mode), .sh_out(sh_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_err(out_err)
    );

    // Stand-in for barrel_shifter: each output bit picks its source bit.
    function automatic logic [31:0] shifter_model(input logic [31:0] d, input logic [4:0] sl,
                                                  input logic dir, input logic [1:0] mode);
        logic [31:0] r;
        int          src;
        logic [4:0]  idx;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            src = dir ? i + int'(sl) : i - int'(sl);
            idx = src[4:0];
            if ((src >= 0 && src < 32) || mode == 2'b01) r[i] = d[idx];
            else if (dir && mode == 2'b10)               r[i] = d[31];
            else                                         r[i] = 1'b0;
        end
        return r;
    endfunction

    assign sh_out = shifter_model(sh_in, sh_sl, sh_dir, sh_mode);

    // Reference: MIPS shift semantics from funct using plain operators.
    function automatic void ref_op(input logic [5:0] f, input logic [4:0] shamt,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   output logic [31:0] data, output logic err);
        int          amt;
        logic [63:0] dbl;
        amt = f[2] ? int'(rs[4:0]) : int'(shamt);
        dbl = {rt, rt};
        err = 1'b0;
        case (f)
            6'd0, 6'd4: data = rt << amt;
            6'd2, 6'd6: data = rt >> amt;
            6'd3, 6'd7: data = $unsigned($signed(rt) >>> amt);
            6'd1, 6'd5: data = 32'(dbl >> amt);
            default: begin data = rt; err = 1'b1; end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [5:0] f, input logic [4:0] shamt,
                            input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
        in_valid = 1'b1;
        in_funct = f;
        in_shamt = shamt;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
    endtask

    typedef struct {
        string       name;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  rd;
        logic [4:0]  e_sl;
        logic        e_dir;
        logic [1:0]  e_mode;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vectors();
        foreach (vecs[v]) begin
            drive_op(vecs[v].funct, vecs[v].shamt, vecs[v].rs, vecs[v].rt, vecs[v].rd);
            out_ready = 1'b1;
            #1;
            check({vecs[v].name, "_in_ready"}, 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            check({vecs[v].name, "_sh_in"},   sh_in, vecs[v].rt);
            check({vecs[v].name, "_sh_sl"},   32'(sh_sl), 32'(vecs[v].e_sl));
            check({vecs[v].name, "_sh_dir"},  32'(sh_dir), 32'(vecs[v].e_dir));
            check({vecs[v].name, "_sh_mode"}, 32'(sh_mode), 32'(vecs[v].e_mode));
            check({vecs[v].name, "_early_valid"}, 32'(out_valid), 32'd0);
            tick();
            check({vecs[v].name, "_out_valid"}, 32'(out_valid), 32'd1);
            check({vecs[v].name, "_out_data"},  out_data, vecs[v].e_data);
            check({vecs[v].name, "_out_rd"},    32'(out_rd), 32'(vecs[v].rd));
            check({vecs[v].name, "_out_err"},   32'(out_err), 32'(vecs[v].e_err));
            tick();
            check({vecs[v].name, "_retired"},   32'(out_valid), 32'd0);
        end
    endtask

    task automatic backpressure();
        logic [31:0] ea, eb, ec;
        logic        er;
        ref_op(6'd0, 5'd1, 32'd0, 32'h0000_0001, ea, er);
        ref_op(6'd2, 5'd4, 32'd0, 32'h0000_0100, eb, er);
        ref_op(6'd1, 5'd1, 32'd0, 32'h0000_0001, ec, er);
        out_ready = 1'b0;
        drive_op(6'd0, 5'd1, 32'd0, 32'h0000_0001, 5'd1);
        @(negedge clk);
        check("bp_accept_a", 32'(in_ready), 32'd1);
        tick();
        drive_op(6'd2, 5'd4, 32'd0, 32'h0000_0100, 5'd2);
        @(negedge clk);
        check("bp_accept_b", 32'(in_ready), 32'd1);
        tick();
        drive_op(6'd1, 5'd1, 32'd0, 32'h0000_0001, 5'd3);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_refuse_c", 32'(in_ready), 32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", out_data, ea);
            check("bp_hold_sh_in", sh_in, 32'h0000_0100);
            check("bp_hold_sh_sl", 32'(sh_sl), 32'd4);
            check("bp_hold_sh_dir", 32'(sh_dir), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_retire_b_valid", 32'(out_valid), 32'd1);
        check("bp_retire_b_data", out_data, eb);
        check("bp_retire_b_rd", 32'(out_rd), 32'd2);
        tick();
        check("bp_retire_c_valid", 32'(out_valid), 32'd1);
        check("bp_retire_c_data", out_data, ec);
        check("bp_retire_c_rd", 32'(out_rd), 32'd3);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);
    endtask

    task automatic midstream_reset();
        out_ready = 1'b0;
        drive_op(6'd0, 5'd3, 32'd0, 32'h0000_00FF, 5'd9);
        tick();
        drive_op(6'd3, 5'd2, 32'd0, 32'h8000_0000, 5'd10);
        tick();
        in_valid = 1'b0;
        check("mr_in_flight", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_out_data", out_data, 32'd0);
        check("mr_sh_in", sh_in, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("mr_no_result", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic random_op(output logic [5:0] f);
        case ($urandom_range(0, 9))
            0: f = 6'd0;  1: f = 6'd2;  2: f = 6'd3;  3: f = 6'd1;
            4: f = 6'd4;  5: f = 6'd6;  6: f = 6'd7;  7: f = 6'd5;
            8: f = 6'h3F;
            default: f = 6'h20;
        endcase
    endtask

    task automatic run_stream(input int n_ops, input int ready_pct, input bit full);
        logic [37:0] q[$];
        logic [37:0] e;
        logic [31:0] d;
        logic        er;
        logic [5:0]  f;
        int          sent, got, cycles;
        bit          pending;
        sent = 0; got = 0; cycles = 0; pending = 0;
        while (got < n_ops && cycles < 2000) begin
            if (!pending && sent < n_ops && (full || $urandom_range(0, 3) != 0)) begin
                random_op(f);
                drive_op(f, 5'($urandom), $urandom, $urandom, 5'($urandom));
                pending = 1;
            end
            in_valid  = pending;
            out_ready = full ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
            @(negedge clk);
            if (full && sent < n_ops) check("stream_no_bubble_ready", 32'(in_ready), 32'd1);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL stream_extra_result: got data %0h with no op outstanding", out_data);
                end else begin
                    e = q.pop_front();
                    check("stream_data", out_data, e[31:0]);
                    check("stream_rd", 32'(out_rd), 32'(e[36:32]));
                    check("stream_err", 32'(out_err), 32'(e[37]));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                ref_op(in_funct, in_shamt, in_rs, in_rt, d, er);
                q.push_back({er, in_rd, d});
                sent++;
                pending = 0;
            end
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        check("stream_all_retired", 32'(got), 32'(n_ops));
        check("stream_queue_empty", 32'(q.size()), 32'd0);
        if (full) check("stream_full_rate_cycles", 32'(cycles), 32'(n_ops + 2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"sll",    6'd0,  5'd4,  32'h0,         32'h0000_0001, 5'd1,  5'd4,  1'b0, 2'b00, 32'h0000_0010, 1'b0};
        vecs[1] = '{"srlv",   6'd6,  5'd17, 32'h0000_0023, 32'h8000_0000, 5'd2,  5'd3,  1'b1, 2'b00, 32'h1000_0000, 1'b0};
        vecs[2] = '{"srav",   6'd7,  5'd0,  32'h0000_0004, 32'h8000_0000, 5'd3,  5'd4,  1'b1, 2'b10, 32'hF800_0000, 1'b0};
        vecs[3] = '{"rotr",   6'd1,  5'd4,  32'h0,         32'h0000_00F1, 5'd4,  5'd4,  1'b1, 2'b01, 32'h1000_000F, 1'b0};
        vecs[4] = '{"rotrv",  6'd5,  5'd1,  32'hFFFF_FFE8, 32'h1234_5678, 5'd5,  5'd8,  1'b1, 2'b01, 32'h7812_3456, 1'b0};
        vecs[5] = '{"srl31",  6'd2,  5'd31, 32'h0,         32'hF000_0000, 5'd6,  5'd31, 1'b1, 2'b00, 32'h0000_0001, 1'b0};
        vecs[6] = '{"sra31",  6'd3,  5'd31, 32'h0,         32'h8000_0000, 5'd8,  5'd31, 1'b1, 2'b10, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{"sllv32", 6'd4,  5'd9,  32'h0000_0020, 32'hABCD_0123, 5'd30, 5'd0,  1'b0, 2'b00, 32'hABCD_0123, 1'b0};
        vecs[8] = '{"bad3f",  6'h3F, 5'd12, 32'h0000_0011, 32'hDEAD_BEEF, 5'd7,  5'd0,  1'b0, 2'b00, 32'hDEAD_BEEF, 1'b1};
        vecs[9] = '{"sll0",   6'd0,  5'd0,  32'hFFFF_FFFF, 32'h8000_0001, 5'd31, 5'd0,  1'b0, 2'b00, 32'h8000_0001, 1'b0};

        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive_op(6'd2, 5'd5, 32'h1, 32'hFFFF_FFFF, 5'd3);
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_sh_in", sh_in, 32'd0);
        check("rst_sh_ctl", 32'({sh_sl, sh_dir, sh_mode}), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_vectors();
        backpressure();
        midstream_reset();
        run_stream(16, 60, 1'b0);
        run_stream(16, 100, 1'b1);
        run_stream(40, 40, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

Two-entry pipelined issue/retire stage wrapped around the ALU `barrel_shifter`. It accepts MIPS R-type shift operations over a valid/ready handshake and decodes `funct`/`shamt`/`rs` into the shifter's control fields (`sl`, direction, mode). It drives those fields from registered operands, captures the shifter's combinational result into an output register, and retires it downstream with backpressure. It sits between the ALU operand-dispatch stage and the writeback mux.

## Interface
- `N`, 32: datapath width. Must equal the shifter width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream operation valid.
- `in_ready`  out  1  stage can accept an operation this cycle.
- `in_funct`  in  6  MIPS funct field.
- `in_shamt`  in  5  immediate shift amount.
- `in_rs`  in  N  variable shift amount source; bits [4:0] are used.
- `in_rt`  in  N  value to shift.
- `in_rd`  in  5  destination tag, passed through.
- `sh_in`  out  N  to shifter `in`.
- `sh_sl`  out  5  to shifter `sl`.
- `sh_dir`  out  1  to shifter direction: 0 = left, 1 = right.
- `sh_mode`  out  2  to shifter mode: 00 = logical, 01 = rotate, 10 = arithmetic.
- `sh_out`  in  N  from shifter `out`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  N  registered result.
- `out_rd`  out  5  registered destination tag.
- `out_err`  out  1  the operation had an unsupported funct.

## Operation
- **Decode** (applied on accept and stored in S1; `sl` source shown in parentheses):
  - 000000 SLL: dir 0, mode 00 (`shamt`).
  - 000010 SRL: dir 1, mode 00 (`shamt`).
  - 000011 SRA: dir 1, mode 10 (`shamt`).
  - 000001 ROTR: dir 1, mode 01 (`shamt`).
  - 000100 SLLV: dir 0, mode 00 (`rs[4:0]`).
  - 000110 SRLV: dir 1, mode 00 (`rs[4:0]`).
  - 000111 SRAV: dir 1, mode 10 (`rs[4:0]`).
  - 000101 ROTRV: dir 1, mode 01 (`rs[4:0]`).
- **Any other funct:** dir 0, mode 00, sl 0, err 1. The shifter then passes `rt` unchanged, and the result is still retired.
- **S1 (issue register):** holds `s1_valid`, `rt`, `sl`, dir, mode, rd and err. `sh_*` outputs are driven directly from S1 registers, never from `in_*` combinationally. When S1 is empty, `sh_*` hold their last values.
- **S2 (result register):** holds `s2_valid`, data, rd and err. `out_*` are driven directly from S2.
- **Control signals:**
  - `s2_free` = !s2_valid | out_ready.
  - `s1_adv` = s1_valid & s2_free.
  - `in_ready` = !s1_valid | s1_adv. This is combinational from `out_ready`; there is no combinational path from `in_valid`.
- **Edge updates:**
  - On `in_valid & in_ready`: S1 loads the decoded op and `s1_valid` is set.
  - Otherwise, on `s1_adv`: `s1_valid` is cleared.
  - On `s1_adv`: S2 loads {`sh_out`, rd, err} and `s2_valid` is set.
  - Otherwise, on `out_valid & out_ready`: `s2_valid` is cleared.
- **Simultaneous accept, advance and retire in one cycle:** all three occur, giving full throughput of one op per cycle.
- **Stall:** with `out_ready` = 0 and both stages full, `in_ready` = 0. S1, S2 and `sh_*` remain stable until `out_ready` rises.
- **Reset (asynchronous, any time, including mid-operation):**
  - `s1_valid` and `s2_valid` are cleared; in-flight ops are dropped, not retired.
  - `sh_in`, `sh_sl`, `sh_dir`, `sh_mode` = 0.
  - `out_data`, `out_rd`, `out_err`, `out_valid` = 0.
  - `in_ready` = 1 after reset.

## Timing
- Latency: an op accepted at edge k drives `sh_*` during cycle k+1. It is captured at edge k+1 when `s2_free`, and `out_valid` = 1 from edge k+1.
- Minimum accept-to-`out_valid` latency is 1 edge. Accept-to-retire is 2 edges with `out_ready` held high.
- Throughput is 1 op/cycle with no bubbles while `out_ready` = 1.
- The shifter is combinational within one cycle. The path is S1 → `barrel_shifter` → S2.
- The stage holds at most 2 ops in flight. A third op is refused until `out_ready` rises.

## Test plan
- Reset with `in_valid` = 1 → `in_ready` = 1, `out_valid` = 0, all outputs 0. Assert `rst_n` low mid-stream with 2 ops in flight → `out_valid` drops immediately and no result appears after release.
- SLL, rt = 0x0000_0001, shamt = 4, `out_ready` = 1 → `sh_sl` = 4, dir 0, mode 00. Two edges after accept, `out_data` = 0x0000_0010 and `out_err` = 0.
- SRLV, rt = 0x8000_0000, rs = 0x0000_0023 → `sh_sl` = 3 (rs[4:0]), dir 1, mode 00, `out_data` = 0x1000_0000. SRAV, ROTR and ROTRV → `sh_dir`/`sh_mode` equal 1/10, 1/01 and 1/01 respectively.
- funct 0x3F, rt = 0xDEAD_BEEF, rd = 7 → `out_data` = 0xDEAD_BEEF, `out_rd` = 7, `out_err` = 1.
- Backpressure: hold `out_ready` = 0 and issue 3 back-to-back ops → the first two are accepted and the third sees `in_ready` = 0. `sh_*` and `out_data` stay stable. Releasing `out_ready` retires all 3 in order on consecutive cycles.
- Streaming: issue 16 random ops with random `out_ready` gaps → results match a golden shifter model in order, with no loss or duplication. With `out_ready` held at 1, there are no bubbles.
